freq_frame_deframer: RTL and testbench

Byte-to-word deframer between `uart_rx` and the 32-bit frequency-offset FIFO of the SSB transmitter. It hunts for a sync byte, assembles a little-endian 32-bit word and optionally checks an XOR checksum. It then emits one write strobe toward the FIFO and answers the host with ACK or NAK through `uart_tx`. It replaces the plain 4-byte counter unpacker, adding resynchronisation, overflow refusal and error statistics.

---
 rtl/freq_frame_deframer_if.sv | 35 +++
 rtl/freq_frame_deframer.sv | 177 +++++++++++++++++
 tb/tb_freq_frame_deframer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_frame_deframer_if.sv
// Byte/word handshake bundle between uart_rx, the deframer, the frequency
// FIFO and uart_tx. The slave modport is the deframer's view; the master
// modport is the surrounding logic that feeds it and consumes its outputs.
interface freq_frame_deframer_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        fifo_full;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic [7:0]  tx_byte_o;
  logic        tx_start_o;
  logic        tx_ready_i;

  modport slave (
    input  rx_byte,
    input  rx_valid,
    input  fifo_full,
    input  tx_ready_i,
    output word_o,
    output word_valid_o,
    output tx_byte_o,
    output tx_start_o
  );

  modport master (
    output rx_byte,
    output rx_valid,
    output fifo_full,
    output tx_ready_i,
    input  word_o,
    input  word_valid_o,
    input  tx_byte_o,
    input  tx_start_o
  );
endinterface

// File: rtl/freq_frame_deframer.sv
// freq_frame_deframer: hunts for SYNC_BYTE, assembles a little-endian 32-bit
// frequency word from the next four bytes, strobes it into the FIFO and
// answers the host with ACK/NAK through a single-entry reply slot.
// Optional feature macro: DEFRAMER_CHECKSUM_EN adds a trailing XOR checksum
// byte (d0^d1^d2^d3) and the CSUM state; without it frames are 5 bytes.
//
// state | meaning
// HUNT  | discard bytes until SYNC_BYTE
// DATA  | collect d0..d3 at byte index idx
// CSUM  | compare next byte against running XOR (checksum build only)
// EVAL  | one cycle: decide write/ACK or NAK, load reply slot
module freq_frame_deframer #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  freq_frame_deframer_if.slave        bus,
  output logic [15:0]                 frame_ok_cnt_o,
  output logic [15:0]                 frame_err_cnt_o,
  output logic                        busy_o
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   IDLE_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   IDLE_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
    S_CSUM = 2'd2,
    S_EVAL = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [31:0]     data_r;
  logic            pending;
  logic [TW-1:0]   idle_left;
  logic            timeout_hit;
  logic            is_sync;
`ifdef DEFRAMER_CHECKSUM_EN
  logic [7:0]      csum_r;
  logic            csum_bad;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Idle timer fires on the TIMEOUT_CYCLES-th consecutive cycle without a
  // byte; a byte on that same cycle wins because timeout_hit needs !rx_valid.
  assign timeout_hit = !bus.rx_valid && (idle_left == IDLE_ONE);
  assign is_sync     = bus.rx_valid && (bus.rx_byte == SYNC_BYTE);

  // Inter-byte idle timer: reloads on every byte, counts down and parks at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_left <= '0;
    end else if (bus.rx_valid) begin
      idle_left <= IDLE_LOAD;
    end else if (idle_left != '0) begin
      idle_left <= idle_left - IDLE_ONE;
    end
  end

  // Frame FSM with registered outputs, reply slot and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_HUNT;
      idx              <= 2'd0;
      data_r           <= 32'd0;
      pending          <= 1'b0;
      bus.word_o       <= 32'd0;
      bus.word_valid_o <= 1'b0;
      bus.tx_byte_o    <= ACK_BYTE;
      bus.tx_start_o   <= 1'b0;
      frame_ok_cnt_o   <= 16'd0;
      frame_err_cnt_o  <= 16'd0;
      busy_o           <= 1'b0;
`ifdef DEFRAMER_CHECKSUM_EN
      csum_r           <= 8'd0;
      csum_bad         <= 1'b0;
`endif
    end else begin
      bus.word_valid_o <= 1'b0;
      bus.tx_start_o   <= 1'b0;

      // EVAL owns the slot that cycle so a fresh reply never launches with
      // a stale start; the newer reply simply replaces the waiting one.
      if (pending && bus.tx_ready_i && (state != S_EVAL)) begin
        bus.tx_start_o <= 1'b1;
        pending        <= 1'b0;
      end

      case (state)
        S_HUNT: begin
          if (is_sync) begin
            state  <= S_DATA;
            idx    <= 2'd0;
            busy_o <= 1'b1;
`ifdef DEFRAMER_CHECKSUM_EN
            csum_r <= 8'd0;
`endif
          end
        end

        S_DATA: begin
          if (bus.rx_valid) begin
            data_r[{idx, 3'b000} +: 8] <= bus.rx_byte;
            idx                        <= idx + 2'd1;
`ifdef DEFRAMER_CHECKSUM_EN
            csum_r <= csum_r ^ bus.rx_byte;
            if (idx == 2'd3) state <= S_CSUM;
`else
            if (idx == 2'd3) state <= S_EVAL;
`endif
          end else if (timeout_hit) begin
            state           <= S_HUNT;
            busy_o          <= 1'b0;
            frame_err_cnt_o <= sat_inc(frame_err_cnt_o);
          end
        end

`ifdef DEFRAMER_CHECKSUM_EN
        S_CSUM: begin
          if (bus.rx_valid) begin
            csum_bad <= (bus.rx_byte != csum_r);
            state    <= S_EVAL;
          end else if (timeout_hit) begin
            state           <= S_HUNT;
            busy_o          <= 1'b0;
            frame_err_cnt_o <= sat_inc(frame_err_cnt_o);
          end
        end
`endif

        S_EVAL: begin
          pending <= 1'b1;
`ifdef DEFRAMER_CHECKSUM_EN
          if (csum_bad || bus.fifo_full) begin
`else
          if (bus.fifo_full) begin
`endif
            bus.tx_byte_o   <= NAK_BYTE;
            frame_err_cnt_o <= sat_inc(frame_err_cnt_o);
          end else begin
            bus.tx_byte_o    <= ACK_BYTE;
            bus.word_o       <= data_r;
            bus.word_valid_o <= 1'b1;
            frame_ok_cnt_o   <= sat_inc(frame_ok_cnt_o);
          end
          // A byte arriving now already belongs to the hunt.
          if (is_sync) begin
            state  <= S_DATA;
            idx    <= 2'd0;
            busy_o <= 1'b1;
`ifdef DEFRAMER_CHECKSUM_EN
            csum_r <= 8'd0;
`endif
          end else begin
            state  <= S_HUNT;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= S_HUNT;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_frame_deframer.sv
// Directed, table-driven bench for freq_frame_deframer with a short idle
// timeout so that timeout behaviour stays cheap to exercise.
module tb_freq_frame_deframer;
  localparam int TO = 50;
`ifdef DEFRAMER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic        busy;

  freq_frame_deframer_if bus();

  freq_frame_deframer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .frame_ok_cnt_o  (ok_cnt),
    .frame_err_cnt_o (err_cnt),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          wv_cnt   = 0;
  int          ts_cnt   = 0;
  logic [7:0]  last_tx  = 8'h00;

  logic [31:0] exp_word;
  int          exp_ok;
  int          exp_err;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.word_valid_o) wv_cnt <= wv_cnt + 1;
    if (bus.tx_start_o) begin
      ts_cnt  <= ts_cnt + 1;
      last_tx <= bus.tx_byte_o;
    end
  end

  typedef struct {
    logic [15:0] junk;
    int          njunk;
    logic [7:0]  b0, b1, b2, b3, cs;
    logic        ff;
    logic        cs_bad;
    logic [31:0] word;
  } vec_t;

  vec_t vec[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, cs);
    send_byte(8'hA5);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    if (CS_EN) send_byte(cs);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_counts();
    chk("ok_cnt", {16'd0, ok_cnt}, exp_ok);
    chk("err_cnt", {16'd0, err_cnt}, exp_err);
  endtask

  initial begin
    int wv0, ts0;
    logic       acc;
    logic [7:0] last;

    vec[0] = '{junk:16'h0000, njunk:0, b0:8'h78, b1:8'h56, b2:8'h34, b3:8'h12, cs:8'h08, ff:1'b0, cs_bad:1'b0, word:32'h12345678};
    vec[1] = '{junk:16'h0000, njunk:0, b0:8'h78, b1:8'h56, b2:8'h34, b3:8'h12, cs:8'hFF, ff:1'b0, cs_bad:1'b1, word:32'h12345678};
    vec[2] = '{junk:16'h0033, njunk:2, b0:8'h01, b1:8'h00, b2:8'h00, b3:8'h00, cs:8'h01, ff:1'b0, cs_bad:1'b0, word:32'h00000001};
    vec[3] = '{junk:16'h0000, njunk:0, b0:8'hA5, b1:8'h00, b2:8'h00, b3:8'h00, cs:8'hA5, ff:1'b0, cs_bad:1'b0, word:32'h000000A5};
    vec[4] = '{junk:16'h0000, njunk:0, b0:8'hEF, b1:8'hBE, b2:8'hAD, b3:8'hDE, cs:8'h22, ff:1'b1, cs_bad:1'b0, word:32'hDEADBEEF};
    vec[5] = '{junk:16'h0000, njunk:0, b0:8'hFF, b1:8'hFF, b2:8'hFF, b3:8'hFF, cs:8'h00, ff:1'b0, cs_bad:1'b0, word:32'hFFFFFFFF};

    rst_n          = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.tx_ready_i = 1'b1;
    exp_word = 32'd0; exp_ok = 0; exp_err = 0;

    // Reset values
    settle(3);
    chk("rst_word", bus.word_o, 32'd0);
    chk("rst_word_valid", {31'd0, bus.word_valid_o}, 32'd0);
    chk("rst_tx_byte", {24'd0, bus.tx_byte_o}, 32'h06);
    chk("rst_tx_start", {31'd0, bus.tx_start_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_counts();
    @(negedge clk);
    rst_n = 1'b1;
    settle(2);

    // Cycle-exact latency: last byte at N, write at N+1, reply start at N+2
    send_byte(8'hA5); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    if (CS_EN) begin
      send_byte(8'h12);
      last = 8'h08;
    end else begin
      last = 8'h12;
    end
    bus.rx_byte = last; bus.rx_valid = 1'b1;
    @(negedge clk); bus.rx_valid = 1'b0; #1;
    chk("lat_wv_N", {31'd0, bus.word_valid_o}, 32'd0);
    @(negedge clk); #1;
    exp_ok = 1; exp_word = 32'h12345678;
    chk("lat_wv_N1", {31'd0, bus.word_valid_o}, 32'd1);
    chk("lat_word_N1", bus.word_o, exp_word);
    chk("lat_ok_N1", {16'd0, ok_cnt}, exp_ok);
    chk("lat_start_N1", {31'd0, bus.tx_start_o}, 32'd0);
    @(negedge clk); #1;
    chk("lat_start_N2", {31'd0, bus.tx_start_o}, 32'd1);
    chk("lat_txbyte_N2", {24'd0, bus.tx_byte_o}, 32'h06);
    chk("lat_wv_N2", {31'd0, bus.word_valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("lat_start_N3", {31'd0, bus.tx_start_o}, 32'd0);

    // Table of frames with tx_ready high
    for (int i = 0; i < 6; i++) begin
      wv0 = wv_cnt; ts0 = ts_cnt;
      bus.fifo_full = vec[i].ff;
      for (int j = vec[i].njunk - 1; j >= 0; j--) send_byte(vec[i].junk[8*j +: 8]);
      send_frame(vec[i].b0, vec[i].b1, vec[i].b2, vec[i].b3, vec[i].cs);
      settle(4);
      bus.fifo_full = 1'b0;
      acc = !vec[i].ff && !(CS_EN && vec[i].cs_bad);
      if (acc) begin
        exp_ok++;
        exp_word = vec[i].word;
      end else begin
        exp_err++;
      end
      chk($sformatf("vec%0d_writes", i), wv_cnt - wv0, acc ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_word", i), bus.word_o, exp_word);
      chk($sformatf("vec%0d_replies", i), ts_cnt - ts0, 32'd1);
      chk($sformatf("vec%0d_reply", i), {24'd0, last_tx}, acc ? 32'h06 : 32'h15);
      chk($sformatf("vec%0d_ok", i), {16'd0, ok_cnt}, exp_ok);
      chk($sformatf("vec%0d_err", i), {16'd0, err_cnt}, exp_err);
    end

    // Timeout mid-frame: fires exactly on the TO-th idle cycle, no reply
    ts0 = ts_cnt; wv0 = wv_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    repeat (TO - 1) @(negedge clk);
    #1;
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    chk("to_busy_after", {31'd0, busy}, 32'd0);
    exp_err++;
    settle(3);
    chk("to_err", {16'd0, err_cnt}, exp_err);
    chk("to_no_reply", ts_cnt - ts0, 32'd0);
    chk("to_no_write", wv_cnt - wv0, 32'd0);
    send_frame(8'hEF, 8'hBE, 8'h00, 8'h00, 8'h51);
    settle(4);
    exp_ok++; exp_word = 32'h0000BEEF;
    chk("to_next_word", bus.word_o, exp_word);
    chk_counts();

    // Back-to-back frames, tx held off; second sync lands in first EVAL
    bus.tx_ready_i = 1'b0;
    ts0 = ts_cnt; wv0 = wv_cnt;
    send_frame(8'h44, 8'h33, 8'h22, 8'h11, 8'h44);
    send_byte(8'hA5);
    bus.fifo_full = 1'b1;
    send_byte(8'h88); send_byte(8'h77); send_byte(8'h66); send_byte(8'h55);
    if (CS_EN) send_byte(8'hCC);
    settle(4);
    bus.fifo_full = 1'b0;
    exp_ok++; exp_err++; exp_word = 32'h11223344;
    chk("b2b_writes", wv_cnt - wv0, 32'd1);
    chk("b2b_word", bus.word_o, exp_word);
    chk("b2b_held", ts_cnt - ts0, 32'd0);
    chk_counts();
    bus.tx_ready_i = 1'b1;
    settle(4);
    chk("b2b_one_reply", ts_cnt - ts0, 32'd1);
    chk("b2b_newest", {24'd0, last_tx}, 32'h15);

    // Reset mid-frame with a NAK reply pending
    bus.tx_ready_i = 1'b0;
    bus.fifo_full  = 1'b1;
    send_frame(8'h04, 8'h03, 8'h02, 8'h01, 8'h04);
    settle(3);
    bus.fifo_full = 1'b0;
    chk("pre_rst_pending", {24'd0, bus.tx_byte_o}, 32'h15);
    send_byte(8'hA5); send_byte(8'h11);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_ok = 0; exp_err = 0; exp_word = 32'd0;
    chk("mid_rst_word", bus.word_o, exp_word);
    chk("mid_rst_tx_byte", {24'd0, bus.tx_byte_o}, 32'h06);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk_counts();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.tx_ready_i = 1'b1;
    ts0 = ts_cnt; wv0 = wv_cnt;
    settle(5);
    chk("post_rst_no_reply", ts_cnt - ts0, 32'd0);
    chk("post_rst_no_write", wv_cnt - wv0, 32'd0);
    send_frame(8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
    settle(4);
    exp_ok = 1; exp_word = 32'h12345678;
    chk("post_rst_word", bus.word_o, exp_word);
    chk("post_rst_reply", {24'd0, last_tx}, 32'h06);
    chk("post_rst_replies", ts_cnt - ts0, 32'd1);
    chk_counts();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
